fixed_point_unit_arbiter: RTL and testbench
===========================================

Name: fixed_point_unit_arbiter

Overview:
Shares one Fixed_Point_Unit (FPU) between N_REQ requesters, such as the execute stage and a coprocessor port.
- Arbitrates round-robin.
- Captures operands and holds the FPU inputs stable for the whole multi-cycle operation.
- Detects completion through the FPU ready output.
- Returns the result to the winning requester over a valid/ready response handshake.
- A watchdog aborts hung operations.

Parameters:
WIDTH, 32, datapath width; must match the FPU.
N_REQ, 2, number of requesters (2..4).
TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before abort.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  N_REQ  per-requester request valid.
req_ready  output  N_REQ  per-requester request accepted (one-hot or zero).
req_operation  input  2*N_REQ  per-requester opcode; slice i = bits [2i+1:2i]; encodings `FPU_ADD/`FPU_SUB/`FPU_MUL/`FPU_SQRT from Defines.vh.
req_operand_1  input  WIDTH*N_REQ  per-requester operand 1, sliced by requester index.
req_operand_2  input  WIDTH*N_REQ  per-requester operand 2, sliced by requester index.
rsp_valid  output  N_REQ  result valid for requester i.
rsp_ready  input  N_REQ  requester i consumes the result.
rsp_result  output  WIDTH  result (shared bus; meaningful where rsp_valid is high).
rsp_error  output  1  high with rsp_valid when the operation timed out.
fpu_operand_1  output  WIDTH  to FPU operand_1.
fpu_operand_2  output  WIDTH  to FPU operand_2.
fpu_operation  output  2  to FPU operation.
fpu_abort  output  1  one-cycle pulse, OR'ed into the FPU's active-high reset.
fpu_result  input  WIDTH  from FPU result.
fpu_ready  input  1  from FPU ready.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, rr_ptr=0, all req_ready/rsp_valid=0, rsp_result=0, rsp_error=0, fpu_operand_*=0, fpu_operation=`FPU_ADD, fpu_abort=0, timeout counter=0.
  - Reset mid-operation discards everything; no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - Winner = first asserted req_valid at or after rr_ptr, wrapping modulo N_REQ.
  - req_ready[winner]=1 combinationally, only in IDLE.
  - On handshake: capture opcode and operands into the FPU-driving registers. For `FPU_SQRT, operand_2 is forced to 0.
  - Record the grant index; set rr_ptr=(winner+1) mod N_REQ; go to ISSUE.
  - With no request valid, stay in IDLE and keep rr_ptr.
- ISSUE:
  - Exactly 1 cycle. fpu_ready is ignored here because it may be stale from the previous operation.
  - Clear the counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If fpu_ready=1: capture fpu_result into rsp_result, rsp_error=0, go to RESPOND.
  - Else if counter==TIMEOUT_CYCLES-1: rsp_result=0, rsp_error=1, pulse fpu_abort for 1 cycle, go to RESPOND.
  - If fpu_ready arrives on the timeout cycle, ready wins and there is no error.
- RESPOND:
  - rsp_valid[grant]=1; rsp_result and rsp_error are held stable until rsp_ready[grant]=1.
  - On that handshake, go to IDLE.
  - rsp_ready on non-granted lanes is ignored.
- Output stability: FPU input registers change only on an IDLE handshake and remain stable through ISSUE, WAIT and RESPOND.
- Minimum turnaround: 1 (accept) + 1 (ISSUE) + FPU latency + 1 (RESPOND) cycles. At most one operation is in flight; no request is accepted outside IDLE.
- Simultaneous requests: strictly round-robin; no requester waits more than N_REQ-1 grants.
- Requesters must hold req_valid and payload until req_ready; dropping req_valid early is legal and simply loses the slot.

Decomposition:
- Opcode encodings stay in Defines.vh (`FPU_*).
- Add `FPU_ARB_* state encodings to Defines.vh.
- One sub-module: fpu_rr_arbiter (combinational round-robin pick, req vector + rr_ptr -> one-hot grant + index). Reusable elsewhere.
- Counter and FSM live in the top module.

Test Plan:
1. Single MUL, requester 0: op1=0x3F00 (15.75), op2=0x1280 (4.625), FBITS=10 -> rsp_valid[0] with rsp_result=0x12360 (72.84375), rsp_error=0; fpu inputs stable throughout WAIT.
2. SQRT, requester 1: op1=0x18F00 (99.75), op2=0xFFFF -> fpu_operand_2 driven 0; rsp_result within 1 LSB of 0x27F3 (~9.987), delivered on rsp_valid[1] only.
3. Both requesters valid every cycle with ADD 1.0+1.0 (0x400+0x400) -> grants alternate 0,1,0,1; each result 0x800; rr_ptr wraps.
4. Response backpressure: rsp_ready[0] held low 5 cycles -> rsp_valid/rsp_result held stable; req_ready stays 0 for requester 1 until the response handshake, then granted next IDLE cycle.
5. Timeout: FPU model never asserts ready, TIMEOUT_CYCLES=8 -> after 8 WAIT cycles, fpu_abort pulses 1 cycle, rsp_valid with rsp_error=1, rsp_result=0; the next request completes normally.
6. Reset asserted low during WAIT -> all outputs return to reset values asynchronously; after release, no stale rsp_valid; the new request gets grant from rr_ptr=0.

Source files
------------

// File: rtl/fixed_point_unit_arbiter_pkg.sv
// rtl/fixed_point_unit_arbiter_pkg.sv - opcode and FSM encodings shared by the FPU arbiter slice
package fixed_point_unit_arbiter_pkg;

    localparam logic [1:0] FPU_ADD  = 2'd0;
    localparam logic [1:0] FPU_SUB  = 2'd1;
    localparam logic [1:0] FPU_MUL  = 2'd2;
    localparam logic [1:0] FPU_SQRT = 2'd3;

    typedef enum logic [1:0] {
        FPU_ARB_IDLE    = 2'd0,
        FPU_ARB_ISSUE   = 2'd1,
        FPU_ARB_WAIT    = 2'd2,
        FPU_ARB_RESPOND = 2'd3
    } fpu_arb_state_e;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// rtl/fpu_rr_arbiter.sv - combinational round-robin pick: first request at or after rr_ptr
module fpu_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_valid && req[IDX_W'(idx)]) begin
                grant_valid           = 1'b1;
                grant_idx             = IDX_W'(idx);
                grant[IDX_W'(idx)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fixed_point_unit_arbiter.sv
// rtl/fixed_point_unit_arbiter.sv - shares one multi-cycle FPU between N_REQ requesters
// with round-robin grant, held FPU inputs, response handshake and a hang watchdog.
module fixed_point_unit_arbiter
    import fixed_point_unit_arbiter_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [2*N_REQ-1:0]     req_operation,
    input  logic [WIDTH*N_REQ-1:0] req_operand_1,
    input  logic [WIDTH*N_REQ-1:0] req_operand_2,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   rsp_error,
    output logic [WIDTH-1:0]       fpu_operand_1,
    output logic [WIDTH-1:0]       fpu_operand_2,
    output logic [1:0]             fpu_operation,
    output logic                   fpu_abort,
    input  logic [WIDTH-1:0]       fpu_result,
    input  logic                   fpu_ready
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    fpu_arb_state_e   state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] opnd1_q, opnd1_d;
    logic [WIDTH-1:0] opnd2_q, opnd2_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_error_q, rsp_error_d;
    logic             abort_q, abort_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;

    fpu_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req         (req_valid),
        .rr_ptr      (rr_ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_comb begin
        sel_op = FPU_ADD;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_op = req_operation[2*i +: 2];
                sel_a  = req_operand_1[WIDTH*i +: WIDTH];
                sel_b  = req_operand_2[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_idx_d  = grant_idx_q;
        op_d         = op_q;
        opnd1_d      = opnd1_q;
        opnd2_d      = opnd2_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        abort_d      = 1'b0;
        cnt_d        = cnt_q;
        req_ready    = '0;
        rsp_valid    = '0;
        case (state_q)
            FPU_ARB_IDLE: begin
                req_ready = arb_grant;
                if (arb_valid) begin
                    op_d        = sel_op;
                    opnd1_d     = sel_a;
                    opnd2_d     = (sel_op == FPU_SQRT) ? '0 : sel_b;
                    grant_idx_d = arb_idx;
                    rr_ptr_d    = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                    state_d     = FPU_ARB_ISSUE;
                end
            end
            // fpu_ready may still be high from the previous operation, so it is not looked at here.
            FPU_ARB_ISSUE: begin
                cnt_d   = '0;
                state_d = FPU_ARB_WAIT;
            end
            FPU_ARB_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (fpu_ready) begin
                    rsp_result_d = fpu_result;
                    rsp_error_d  = 1'b0;
                    state_d      = FPU_ARB_RESPOND;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_result_d = '0;
                    rsp_error_d  = 1'b1;
                    abort_d      = 1'b1;
                    state_d      = FPU_ARB_RESPOND;
                end
            end
            FPU_ARB_RESPOND: begin
                rsp_valid[grant_idx_q] = 1'b1;
                if (rsp_ready[grant_idx_q]) begin
                    state_d = FPU_ARB_IDLE;
                end
            end
            default: state_d = FPU_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FPU_ARB_IDLE;
            rr_ptr_q     <= '0;
            grant_idx_q  <= '0;
            op_q         <= FPU_ADD;
            opnd1_q      <= '0;
            opnd2_q      <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
            abort_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_idx_q  <= grant_idx_d;
            op_q         <= op_d;
            opnd1_q      <= opnd1_d;
            opnd2_q      <= opnd2_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
            abort_q      <= abort_d;
            cnt_q        <= cnt_d;
        end
    end

    assign fpu_operand_1 = opnd1_q;
    assign fpu_operand_2 = opnd2_q;
    assign fpu_operation = op_q;
    assign fpu_abort     = abort_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_error     = rsp_error_q;

endmodule

// File: tb/tb_fixed_point_unit_arbiter.sv
// tb/tb_fixed_point_unit_arbiter.sv - self-checking bench for fixed_point_unit_arbiter with an FPU stub
module tb_fixed_point_unit_arbiter;
    import fixed_point_unit_arbiter_pkg::*;

    localparam int FBITS = 10;

    typedef struct {
        logic [31:0] res;
        logic        err;
        logic [1:0]  vvec;
        int          cycles;
        int          aborts;
        int          unstable;
        logic [31:0] fa;
        logic [31:0] fb;
        logic [1:0]  fop;
        bit          to;
    } rsp_obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready;
    logic [3:0]  req_operation;
    logic [63:0] req_operand_1, req_operand_2;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_error;
    logic [31:0] fpu_operand_1, fpu_operand_2;
    logic [1:0]  fpu_operation;
    logic        fpu_abort;
    logic [31:0] fpu_result;
    logic        fpu_ready;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int exp_ptr  = 0;
    int fpu_lat  = 3;
    bit fpu_hang = 1'b0;

    always #5 clk = ~clk;

    fixed_point_unit_arbiter #(.WIDTH(32), .N_REQ(2), .TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_operation (req_operation),
        .req_operand_1 (req_operand_1),
        .req_operand_2 (req_operand_2),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_error     (rsp_error),
        .fpu_operand_1 (fpu_operand_1),
        .fpu_operand_2 (fpu_operand_2),
        .fpu_operation (fpu_operation),
        .fpu_abort     (fpu_abort),
        .fpu_result    (fpu_result),
        .fpu_ready     (fpu_ready)
    );

    function automatic logic [31:0] isqrt64(input logic [63:0] v);
        logic [63:0] r, t;
        r = 0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= v) r = t;
        end
        return r[31:0];
    endfunction

    function automatic logic [31:0] ref_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            FPU_ADD: return a + b;
            FPU_SUB: return a - b;
            FPU_MUL: begin
                p = {32'd0, a} * {32'd0, b};
                return p[FBITS +: 32];
            end
            default: return isqrt64({32'd0, a} << FBITS);
        endcase
    endfunction

    // FPU stub: ready stays high after completion until the cycle after the next ISSUE
    int m_cnt;
    bit m_busy, m_issue;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_issue = 0; m_cnt = 0;
            fpu_ready  <= 1'b0;
            fpu_result <= '0;
        end else begin
            if (fpu_abort) begin
                m_busy = 0; m_issue = 0;
                fpu_ready <= 1'b0;
            end else if (m_issue) begin
                m_issue = 0; m_busy = 1; m_cnt = fpu_lat;
                fpu_ready <= 1'b0;
            end else if (m_busy && !fpu_hang) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 0;
                    fpu_ready  <= 1'b1;
                    fpu_result <= ref_calc(fpu_operation, fpu_operand_1, fpu_operand_2);
                end
            end
            if (|(req_valid & req_ready)) m_issue = 1;
        end
    end

    task automatic drive_lane(input int r, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_operation[2*r +: 2]  = op;
        req_operand_1[32*r +: 32] = a;
        req_operand_2[32*r +: 32] = b;
        req_valid[r] = 1'b1;
    endtask

    task automatic wait_accept(output int idx, output logic [1:0] rv, output bit to);
        to = 1; idx = -1; rv = '0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (|req_ready) begin
                rv = req_ready; idx = req_ready[1] ? 1 : 0; to = 0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic wait_resp(input int r, input int hold, output rsp_obs_t o);
        o.to = 1; o.cycles = 0; o.aborts = 0; o.unstable = 0;
        o.res = '0; o.err = 1'b0; o.vvec = '0;
        #1;
        o.fa = fpu_operand_1; o.fb = fpu_operand_2; o.fop = fpu_operation;
        for (int c = 0; c < 200; c++) begin
            if (c != 0) begin @(negedge clk); #1; end
            if ({fpu_operand_1, fpu_operand_2, fpu_operation} !== {o.fa, o.fb, o.fop}) o.unstable++;
            if (fpu_abort) o.aborts++;
            if (rsp_valid[r]) begin
                o.res = rsp_result; o.err = rsp_error; o.vvec = rsp_valid; o.to = 0;
                break;
            end
            o.cycles++;
        end
        repeat (hold) begin @(negedge clk); #1; if (fpu_abort) o.aborts++; end
        rsp_ready[r] = 1'b1;
        @(negedge clk);
        rsp_ready[r] = 1'b0;
        #1;
        if (fpu_abort) o.aborts++;
    endtask

    task automatic test_reset();
        chk_cnt++;
        if ({req_ready, rsp_valid, rsp_error, fpu_abort} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000", {req_ready, rsp_valid, rsp_error, fpu_abort});
        else pass_cnt++;
        chk_cnt++;
        if ({rsp_result, fpu_operand_1, fpu_operand_2} !== 96'd0)
            $display("FAIL reset_data: got %h/%h/%h expected zeros", rsp_result, fpu_operand_1, fpu_operand_2);
        else pass_cnt++;
        chk_cnt++;
        if (fpu_operation !== FPU_ADD) $display("FAIL reset_op: got %0d expected %0d", fpu_operation, FPU_ADD);
        else pass_cnt++;
    endtask

    task automatic test_mul();
        int idx; logic [1:0] rv; bit to; rsp_obs_t o;
        fpu_lat = 5;
        drive_lane(0, FPU_MUL, 32'h3F00, 32'h1280);
        wait_accept(idx, rv, to);
        req_valid = '0;
        chk_cnt++;
        if (to || idx != 0) $display("FAIL mul_grant: got idx %0d timeout %0d expected 0", idx, to);
        else pass_cnt++;
        exp_ptr = 1;
        wait_resp(0, 0, o);
        chk_cnt++;
        if (o.to || o.res !== 32'h12360 || o.err !== 1'b0)
            $display("FAIL mul_result: got %h err %b expected 00012360 err 0", o.res, o.err);
        else pass_cnt++;
        chk_cnt++;
        if (o.unstable != 0 || {o.fa, o.fb, o.fop} !== {32'h3F00, 32'h1280, FPU_MUL})
            $display("FAIL mul_inputs: got %h %h %0d unstable %0d expected 3f00 1280 %0d", o.fa, o.fb, o.fop, o.unstable, FPU_MUL);
        else pass_cnt++;
        chk_cnt++;
        if (o.cycles != 7) $display("FAIL mul_latency: got %0d expected 7", o.cycles);
        else pass_cnt++;
    endtask

    task automatic test_sqrt();
        int idx; logic [1:0] rv; bit to; rsp_obs_t o; int diff;
        fpu_lat = 4;
        drive_lane(1, FPU_SQRT, 32'h18F00, 32'hFFFF);
        wait_accept(idx, rv, to);
        req_valid = '0;
        chk_cnt++;
        if (to || rv !== 2'b10) $display("FAIL sqrt_grant: got %b expected 10", rv);
        else pass_cnt++;
        exp_ptr = 0;
        wait_resp(1, 0, o);
        chk_cnt++;
        if (o.fb !== 32'd0 || o.fa !== 32'h18F00) $display("FAIL sqrt_operand2: got %h/%h expected 00018f00/00000000", o.fa, o.fb);
        else pass_cnt++;
        diff = int'(o.res) - 32'h27F3;
        chk_cnt++;
        if (o.to || diff > 1 || diff < -1 || o.err !== 1'b0 || o.vvec !== 2'b10)
            $display("FAIL sqrt_result: got %h lanes %b err %b expected ~000027f3 lanes 10 err 0", o.res, o.vvec, o.err);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int gr[4], rl[4]; logic [31:0] rr[4]; int ng, nr, w;
        fpu_lat = 1; ng = 0; nr = 0;
        drive_lane(0, FPU_ADD, 32'h400, 32'h400);
        drive_lane(1, FPU_ADD, 32'h400, 32'h400);
        rsp_ready = 2'b11;
        for (int c = 0; c < 400 && nr < 4; c++) begin
            if (ng >= 4) req_valid = '0;
            #1;
            if (|req_ready && ng < 4) begin
                gr[ng] = (req_ready == 2'b10) ? 1 : ((req_ready == 2'b01) ? 0 : -1);
                ng++;
            end
            if (|rsp_valid) begin
                rl[nr] = (rsp_valid == 2'b10) ? 1 : ((rsp_valid == 2'b01) ? 0 : -1);
                rr[nr] = rsp_result;
                nr++;
            end
            @(negedge clk);
        end
        rsp_ready = '0;
        req_valid = '0;
        chk_cnt++;
        if (ng != 4 || nr != 4) $display("FAIL rr_count: got %0d grants %0d responses expected 4/4", ng, nr);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            w = exp_ptr;
            exp_ptr = (w + 1) % 2;
            chk_cnt++;
            if (gr[k] != w || rl[k] != w || rr[k] !== 32'h800)
                $display("FAIL rr_txn%0d: got grant %0d lane %0d result %h expected %0d/%0d/00000800", k, gr[k], rl[k], rr[k], w, w);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int idx; logic [1:0] rv; bit to; rsp_obs_t o; int bad; bit seen;
        fpu_lat = 2; bad = 0; seen = 0;
        drive_lane(0, FPU_SUB, 32'h5000, 32'h1400);
        wait_accept(idx, rv, to);
        req_valid[0] = 1'b0;
        exp_ptr = 1;
        drive_lane(1, FPU_ADD, 32'h111, 32'h222);
        for (int c = 0; c < 200; c++) begin
            #1;
            if (req_ready !== 2'b00) bad++;
            if (rsp_valid[0]) begin seen = 1; break; end
            @(negedge clk);
        end
        rsp_ready = 2'b10;
        repeat (5) begin
            @(negedge clk); #1;
            if (rsp_valid !== 2'b01 || rsp_result !== 32'h3C00 || rsp_error !== 1'b0 || req_ready !== 2'b00) bad++;
        end
        chk_cnt++;
        if (!seen || bad != 0) $display("FAIL bp_hold: got %0d violations seen %0d expected 0 violations", bad, seen);
        else pass_cnt++;
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        chk_cnt++;
        if (req_ready !== 2'b10) $display("FAIL bp_next_grant: got %b expected 10", req_ready);
        else pass_cnt++;
        wait_accept(idx, rv, to);
        req_valid = '0;
        exp_ptr = 0;
        wait_resp(1, 0, o);
        chk_cnt++;
        if (o.to || o.res !== 32'h333 || o.vvec !== 2'b10) $display("FAIL bp_second: got %h lanes %b expected 00000333 lanes 10", o.res, o.vvec);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int idx; logic [1:0] rv; bit to; rsp_obs_t o;
        fpu_hang = 1'b1;
        drive_lane(0, FPU_MUL, 32'h400, 32'h400);
        wait_accept(idx, rv, to);
        req_valid = '0;
        exp_ptr = 1;
        wait_resp(0, 0, o);
        fpu_hang = 1'b0;
        chk_cnt++;
        if (o.to || o.res !== 32'd0 || o.err !== 1'b1 || o.vvec !== 2'b01)
            $display("FAIL timeout_rsp: got %h err %b lanes %b expected 00000000 err 1 lanes 01", o.res, o.err, o.vvec);
        else pass_cnt++;
        chk_cnt++;
        if (o.cycles != 9 || o.aborts != 1) $display("FAIL timeout_timing: got %0d cycles %0d aborts expected 9/1", o.cycles, o.aborts);
        else pass_cnt++;
        fpu_lat = 3;
        drive_lane(1, FPU_ADD, 32'h1000, 32'h234);
        wait_accept(idx, rv, to);
        req_valid = '0;
        exp_ptr = 0;
        wait_resp(1, 0, o);
        chk_cnt++;
        if (o.to || o.res !== 32'h1234 || o.err !== 1'b0 || o.cycles != 5)
            $display("FAIL timeout_recover: got %h err %b cycles %0d expected 00001234 err 0 cycles 5", o.res, o.err, o.cycles);
        else pass_cnt++;
    endtask

    task automatic test_timeout_boundary();
        int idx; logic [1:0] rv; bit to; rsp_obs_t o;
        fpu_lat = 8;
        drive_lane(0, FPU_ADD, 32'h10, 32'h20);
        wait_accept(idx, rv, to);
        req_valid = '0;
        exp_ptr = 1;
        wait_resp(0, 0, o);
        chk_cnt++;
        if (o.to || o.err !== 1'b1 || o.res !== 32'd0 || o.aborts != 1)
            $display("FAIL bound_late: got %h err %b aborts %0d expected 00000000 err 1 aborts 1", o.res, o.err, o.aborts);
        else pass_cnt++;
        fpu_lat = 7;
        drive_lane(1, FPU_SUB, 32'h9876, 32'h1111);
        wait_accept(idx, rv, to);
        req_valid = '0;
        exp_ptr = 0;
        wait_resp(1, 0, o);
        chk_cnt++;
        if (o.to || o.err !== 1'b0 || o.res !== 32'h8765 || o.aborts != 0 || o.cycles != 9)
            $display("FAIL bound_ontime: got %h err %b aborts %0d cycles %0d expected 00008765 err 0 aborts 0 cycles 9", o.res, o.err, o.aborts, o.cycles);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        int idx; logic [1:0] rv; bit to; rsp_obs_t o; int stale;
        fpu_hang = 1'b1; stale = 0;
        drive_lane(0, FPU_MUL, 32'hABCD, 32'h1234);
        wait_accept(idx, rv, to);
        req_valid = '0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_cnt++;
        if ({rsp_valid, rsp_error, fpu_abort, rsp_result, fpu_operand_1, fpu_operand_2} !== 68'd0 || fpu_operation !== FPU_ADD)
            $display("FAIL midreset_async: got op1 %h op %0d result %h lanes %b expected zeros op %0d", fpu_operand_1, fpu_operation, rsp_result, rsp_valid, FPU_ADD);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        fpu_hang = 1'b0;
        exp_ptr = 0;
        repeat (4) begin #1; if (rsp_valid !== 2'b00) stale++; @(negedge clk); end
        chk_cnt++;
        if (stale != 0) $display("FAIL midreset_stale: got %0d stale responses expected 0", stale);
        else pass_cnt++;
        fpu_lat = 2;
        drive_lane(0, FPU_ADD, 32'h7, 32'h8);
        drive_lane(1, FPU_ADD, 32'h70, 32'h80);
        wait_accept(idx, rv, to);
        req_valid = '0;
        chk_cnt++;
        if (to || rv !== 2'b01) $display("FAIL midreset_grant: got %b expected 01", rv);
        else pass_cnt++;
        exp_ptr = 1;
        wait_resp(0, 0, o);
        chk_cnt++;
        if (o.to || o.res !== 32'hF || o.err !== 1'b0) $display("FAIL midreset_result: got %h expected 0000000f", o.res);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int idx, w, hold; logic [1:0] rv, mask; bit to; rsp_obs_t o;
        logic [1:0] ops[2]; logic [31:0] av[2], bv[2], exp_res, exp_b;
        for (int it = 0; it < 24; it++) begin
            mask = 2'($urandom_range(1, 3));
            fpu_lat = $urandom_range(1, 6);
            hold = $urandom_range(0, 3);
            for (int l = 0; l < 2; l++) begin
                ops[l] = 2'($urandom_range(0, 3));
                av[l] = $urandom_range(0, 32'hFFFFF);
                bv[l] = $urandom_range(0, 32'hFFFFF);
                if (mask[l]) drive_lane(l, ops[l], av[l], bv[l]);
            end
            w = mask[exp_ptr] ? exp_ptr : 1 - exp_ptr;
            wait_accept(idx, rv, to);
            req_valid = '0;
            chk_cnt++;
            if (to || rv !== 2'(1 << w)) $display("FAIL rand%0d_grant: got %b expected lane %0d", it, rv, w);
            else pass_cnt++;
            exp_ptr = (w + 1) % 2;
            exp_res = ref_calc(ops[w], av[w], bv[w]);
            exp_b = (ops[w] == FPU_SQRT) ? 32'd0 : bv[w];
            wait_resp(w, hold, o);
            chk_cnt++;
            if (o.to || o.res !== exp_res || o.err !== 1'b0 || o.vvec !== 2'(1 << w) || o.unstable != 0
                || {o.fa, o.fb, o.fop} !== {av[w], exp_b, ops[w]})
                $display("FAIL rand%0d_rsp: got %h err %b lanes %b fb %h expected %h err 0 lane %0d fb %h", it, o.res, o.err, o.vvec, o.fb, exp_res, w, exp_b);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1'b0;
        req_valid = '0; req_operation = '0; req_operand_1 = '0; req_operand_2 = '0;
        rsp_ready = '0;
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_mul();
        test_sqrt();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
